dense_layer_folded: RTL and testbench
=====================================

Name: dense_layer_folded

Overview:
- Resource-folded successor to the fully-parallel dense layer used in the jet-tagging MLP chain.
- Computes y = act(W·x + b) using only PAR multipliers, time-multiplexed over output groups and input terms.
- Adds valid/ready handshakes with backpressure, an optional fused ReLU, and saturating requantisation.
- Drops into the network chain between layers. The softmax stage or the next layer connects to its output side.

Parameters:
- WIDTH, 8, total bits of signed fixed-point data, weights and bias.
- NFRAC, 4, fractional bits of data, weights and bias.
- INPUT_SIZE, 16, number of input features.
- OUTPUT_SIZE, 64, number of output neurons.
- PAR, 8, neurons computed concurrently, 1..OUTPUT_SIZE. NGROUPS = ceil(OUTPUT_SIZE/PAR).
- ACC_WIDTH, 2*WIDTH+$clog2(INPUT_SIZE)+1, accumulator width. No internal overflow is possible.
- USE_RELU, 1, 1 = clamp negative results to 0 before saturation.
- WEIGHTS, all zeros, signed [WIDTH-1:0] array indexed [OUTPUT_SIZE][INPUT_SIZE], element [o][i].
- BIAS, all zeros, signed [WIDTH-1:0] array indexed [OUTPUT_SIZE].

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input_data valid.
- in_ready  out  1  block can capture input this cycle.
- input_data  in  WIDTH x INPUT_SIZE  signed input vector.
- out_valid  out  1  output_data holds a completed result.
- out_ready  in  1  downstream accepts result.
- output_data  out  WIDTH x OUTPUT_SIZE  signed result vector.
- busy  out  1  high in COMPUTE.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high; it takes effect on the next rising edge.
- Reset:
  - state is IDLE.
  - out_valid, busy and all output_data are 0.
  - Accumulators, group counter g and term counter k are 0.
  - in_ready reads 1 after reset deasserts.
- FSM states: IDLE, COMPUTE, WRITEBACK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register input_data into x_reg, g=0, k=0, load each accumulator j with BIAS[g*PAR+j] <<< NFRAC (sign-extended), then go to COMPUTE.
- COMPUTE, one input term per cycle:
  - For each lane j: acc[j] += x_reg[k] * WEIGHTS[g*PAR+j][k], full signed product of 2*WIDTH bits.
  - k increments. After k = INPUT_SIZE-1, go to WRITEBACK.
- WRITEBACK, one cycle, per lane j with o = g*PAR+j < OUTPUT_SIZE:
  - r = acc[j] >>> NFRAC (arithmetic shift, floor rounding).
  - If USE_RELU and r<0, then r=0.
  - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and write output_data[o].
  - Lanes with o >= OUTPUT_SIZE (last partial group) are ignored.
  - If g < NGROUPS-1: g++, k=0, reload accumulators with the next group's bias, return to COMPUTE.
  - Otherwise go to DONE with out_valid=1.
- Latency: input captured at edge E, out_valid high after edge E + NGROUPS*(INPUT_SIZE+1).
- DONE:
  - out_valid=1. output_data is stable until the handshake completes.
  - in_ready = out_ready.
  - out_valid && out_ready with in_valid: capture new input in the same cycle, go to COMPUTE, out_valid drops next cycle.
  - out_valid && out_ready without in_valid: go to IDLE.
  - out_ready low: hold indefinitely.
- Data stability:
  - In COMPUTE and WRITEBACK, in_ready=0 and input_data is ignored. The x_reg copy is used.
  - output_data is rewritten group by group during the next computation. Consumers must sample only on out_valid && out_ready.
- Reset mid-operation: at any state, aborts the computation and returns to reset values. The partial result is discarded and out_valid never pulses.
- Degenerate configurations:
  - PAR=OUTPUT_SIZE gives NGROUPS=1.
  - INPUT_SIZE=1 gives a 2-cycle compute per group.

Test Plan (WIDTH=8, NFRAC=4, INPUT_SIZE=4, OUTPUT_SIZE=3, PAR=2, USE_RELU=1):
1. Weights and bias as follows:
   - Row0 weights all 0x08 (0.5), bias 0x04.
   - Row1 weights all 0x20 (2.0), bias 0.
   - Row2 weights all 0xF0 (-1.0), bias 0.
   - Input all 0x10 (1.0), out_ready=1.
   - Expected: out_valid rises exactly 10 cycles after capture. output_data = {0x24, 0x7F (saturated from 128), 0x00 (ReLU of -64)}.
2. Same as scenario 1 with USE_RELU=0: output_data[2]=0xC0 (-4.0); other outputs unchanged.
3. Truncation, with a single input 0x01 and all others 0, bias 0:
   - Weight 0x08 gives 0x00.
   - Weight 0xF8 gives 0xFF, i.e. floor of -1/32 gives -1/16.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
   - out_valid stays 1, output_data is unchanged, in_ready=0, in_valid pulses are ignored.
   - Release out_ready: exactly one handshake occurs.
5. Back-to-back: in_valid held high, out_ready=1, two distinct input vectors.
   - Second vector captured on the same edge as the first result's handshake.
   - Results arrive 11 cycles apart and both are correct.
6. Assert reset for one cycle at cycle 4 of COMPUTE.
   - Next cycle: state IDLE, out_valid=0, output_data all 0, in_ready=1.
   - A following input produces a correct result with no residue from the aborted run.

Source files
------------

// File: rtl/dense_layer_folded.sv
// Folded dense layer: y = act(W*x + b) computed with PAR multipliers, one output group
// and one input term per cycle, behind valid/ready handshakes on both sides.
module dense_layer_folded #(
  parameter int WIDTH       = 8,
  parameter int NFRAC       = 4,
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = 64,
  parameter int PAR         = 8,
  parameter int ACC_WIDTH   = 2 * WIDTH + $clog2(INPUT_SIZE) + 1,
  parameter int USE_RELU    = 1,
  parameter logic signed [WIDTH-1:0] WEIGHTS [OUTPUT_SIZE][INPUT_SIZE] = '{default: '0},
  parameter logic signed [WIDTH-1:0] BIAS [OUTPUT_SIZE] = '{default: '0}
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INPUT_SIZE-1:0][WIDTH-1:0]      input_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]     output_data,
  output logic                                  busy
);

  localparam int NGROUPS = (OUTPUT_SIZE + PAR - 1) / PAR;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int KW      = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic [GW-1:0] G_LAST = GW'(NGROUPS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(INPUT_SIZE - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    WRITEBACK,
    DONE
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [GW-1:0]                 g;
  logic [KW-1:0]                 k;
  logic [GW-1:0]                 load_g;
  logic                          start;
  logic                          next_group;
  logic signed [WIDTH-1:0]       x_reg [INPUT_SIZE];
  logic signed [ACC_WIDTH-1:0]   acc   [PAR];
  logic signed [2*WIDTH-1:0]     prod  [PAR];

  // Weight of lane 'lane' in group 'gi' for input term 'ki'; lanes past the last neuron read 0.
  function automatic logic signed [WIDTH-1:0] weight_of(input logic [GW-1:0] gi, input int lane,
                                                        input logic [KW-1:0] ki);
    logic signed [WIDTH-1:0] w;
    w = '0;
    for (int o = 0; o < OUTPUT_SIZE; o++)
      for (int i = 0; i < INPUT_SIZE; i++)
        if ((o % PAR) == lane && gi == GW'(o / PAR) && ki == KW'(i))
          w = WEIGHTS[o][i];
    return w;
  endfunction

  // Bias aligned to the product's binary point (2*NFRAC fractional bits).
  function automatic logic signed [ACC_WIDTH-1:0] bias_ext(input logic [GW-1:0] gi, input int lane);
    logic signed [WIDTH-1:0] b;
    b = '0;
    for (int o = 0; o < OUTPUT_SIZE; o++)
      if ((o % PAR) == lane && gi == GW'(o / PAR))
        b = BIAS[o];
    return ACC_WIDTH'(b) <<< NFRAC;
  endfunction

  // Floor-shift back to NFRAC fractional bits, optional ReLU, then saturate to WIDTH.
  function automatic logic [WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = a >>> NFRAC;
    if (USE_RELU != 0 && r[ACC_WIDTH-1])
      r = '0;
    if (r > SAT_MAX)
      r = SAT_MAX;
    else if (r < SAT_MIN)
      r = SAT_MIN;
    return r[WIDTH-1:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (k == K_LAST)
          state_next = WRITEBACK;
      end
      WRITEBACK: begin
        state_next = (g == G_LAST) ? DONE : COMPUTE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready)
          state_next = in_valid ? COMPUTE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start      = in_valid && in_ready;
  assign next_group = (state == WRITEBACK) && (g != G_LAST);
  assign load_g     = start ? '0 : g + GW'(1);

  always_comb begin
    for (int j = 0; j < PAR; j++)
      prod[j] = (2 * WIDTH)'(x_reg[k]) * (2 * WIDTH)'(weight_of(g, j, k));
  end

  // NOTE: x_reg has no reset; it is always loaded on capture before COMPUTE reads it.
  always_ff @(posedge clk) begin
    if (start)
      for (int i = 0; i < INPUT_SIZE; i++)
        x_reg[i] <= input_data[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g           <= '0;
      k           <= '0;
      output_data <= '0;
      for (int j = 0; j < PAR; j++)
        acc[j] <= '0;
    end else begin
      if (state == COMPUTE) begin
        for (int j = 0; j < PAR; j++)
          acc[j] <= acc[j] + ACC_WIDTH'(prod[j]);
        k <= (k == K_LAST) ? '0 : k + KW'(1);
      end

      // Only neurons of the current group are rewritten; padding lanes have no target.
      if (state == WRITEBACK)
        for (int o = 0; o < OUTPUT_SIZE; o++)
          if (g == GW'(o / PAR))
            output_data[o] <= requant(acc[o % PAR]);

      if (next_group)
        g <= g + GW'(1);

      if (start || next_group)
        for (int j = 0; j < PAR; j++)
          acc[j] <= bias_ext(load_g, j);

      if (start) begin
        g <= '0;
        k <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_folded.sv
// Bench for dense_layer_folded: three lockstep instances (ReLU, no ReLU, truncation weights)
// driven by directed and random traffic, scored against an integer-arithmetic model.
module tb_dense_layer_folded;

  localparam int NI = 4;
  localparam int NO = 3;

  typedef logic signed [7:0] wmat_t [NO][NI];
  typedef logic signed [7:0] bvec_t [NO];
  typedef logic [NI-1:0][7:0] xvec_t;
  typedef logic [NO-1:0][7:0] yvec_t;

  localparam wmat_t W_A = '{'{8'sh08, 8'sh08, 8'sh08, 8'sh08},
                            '{8'sh20, 8'sh20, 8'sh20, 8'sh20},
                            '{8'shF0, 8'shF0, 8'shF0, 8'shF0}};
  localparam bvec_t B_A = '{8'sh04, 8'sh00, 8'sh00};
  localparam wmat_t W_C = '{'{8'sh08, 8'sh08, 8'sh08, 8'sh08},
                            '{8'shF8, 8'shF8, 8'shF8, 8'shF8},
                            '{8'sh7F, 8'sh80, 8'sh13, 8'shE5}};
  localparam bvec_t B_C = '{8'sh00, 8'sh00, 8'sh05};

  logic  clk = 1'b0;
  logic  reset;
  logic  in_valid;
  logic  out_ready;
  xvec_t input_data;
  logic  in_ready_s  [3];
  logic  out_valid_s [3];
  logic  busy_s      [3];
  yvec_t out_s       [3];

  int n_checks = 0;
  int n_errors = 0;
  int hs_count = 0;
  xvec_t xq [$];

  always #5 clk = ~clk;

  dense_layer_folded #(.WIDTH(8), .NFRAC(4), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO), .PAR(2),
                       .USE_RELU(1), .WEIGHTS(W_A), .BIAS(B_A)) dut_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .input_data(input_data), .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .output_data(out_s[0]), .busy(busy_s[0]));

  dense_layer_folded #(.WIDTH(8), .NFRAC(4), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO), .PAR(2),
                       .USE_RELU(0), .WEIGHTS(W_A), .BIAS(B_A)) dut_lin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .input_data(input_data), .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .output_data(out_s[1]), .busy(busy_s[1]));

  dense_layer_folded #(.WIDTH(8), .NFRAC(4), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO), .PAR(2),
                       .USE_RELU(0), .WEIGHTS(W_C), .BIAS(B_C)) dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s[2]),
    .input_data(input_data), .out_valid(out_valid_s[2]), .out_ready(out_ready),
    .output_data(out_s[2]), .busy(busy_s[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product, floor division by 16, ReLU, clamp to int8.
  function automatic yvec_t model(input wmat_t w, input bvec_t b, input bit relu, input xvec_t x);
    yvec_t y;
    int    acc;
    int    r;
    for (int o = 0; o < NO; o++) begin
      acc = int'(b[o]) * 16;
      for (int i = 0; i < NI; i++)
        acc += int'($signed(x[i])) * int'(w[o][i]);
      r = (acc >= 0) ? acc / 16 : -((-acc + 15) / 16);
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      y[o] = 8'(r);
    end
    return y;
  endfunction

  // Scoreboard: every handshake is checked on all three instances.
  always @(negedge clk) begin
    if (reset) begin
      xq.delete();
    end else begin
      if (in_valid && in_ready_s[0])
        xq.push_back(input_data);
      if (out_valid_s[0] && out_ready) begin
        hs_count++;
        check("hs_pending", 32'(xq.size() > 0), 1);
        if (xq.size() > 0) begin
          xvec_t x;
          x = xq.pop_front();
          check("res_relu", out_s[0], model(W_A, B_A, 1'b1, x));
          check("res_lin", out_s[1], model(W_A, B_A, 1'b0, x));
          check("res_trunc", out_s[2], model(W_C, B_C, 1'b0, x));
          check("lockstep_valid", {out_valid_s[1], out_valid_s[2]}, 2'b11);
        end
      end
    end
  end

  task automatic send(input xvec_t x, input bit hold);
    bit captured;
    captured   = 1'b0;
    in_valid   = 1'b1;
    input_data = x;
    for (int c = 0; c < 200 && !captured; c++) begin
      #1;
      captured = in_ready_s[0];
      @(posedge clk);
      #1;
    end
    if (!hold) in_valid = 1'b0;
    check("send_captured", captured, 1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid_s[0] && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int    cyc;
    int    h0;
    bit    seen;
    xvec_t x;
    xvec_t x2;
    yvec_t exp_y;

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    input_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_s[0], 0);
    check("rst_busy", busy_s[0], 0);
    check("rst_out_data", out_s[0], 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_s[0], 1);

    // Test plan values, ReLU and linear instances side by side.
    send({4{8'h10}}, 1'b0);
    check("compute_busy", busy_s[0], 1);
    check("compute_in_ready", in_ready_s[0], 0);
    wait_valid(cyc);
    check("latency", cyc, 10);
    check("plan_relu", out_s[0], 24'h007F24);
    check("plan_linear", out_s[1], 24'hC07F24);
    @(posedge clk);
    #1;
    check("idle_after_hs", out_valid_s[0], 0);
    check("idle_in_ready", in_ready_s[0], 1);

    // Floor truncation of tiny products.
    send(32'h0000_0001, 1'b0);
    wait_valid(cyc);
    check("trunc_out", out_s[2], 24'h0CFF00);
    @(posedge clk);
    #1;

    // Backpressure: result held, in_valid pulses ignored, exactly one handshake on release.
    out_ready = 1'b0;
    x = xvec_t'($urandom);
    exp_y = model(W_A, B_A, 1'b1, x);
    send(x, 1'b0);
    wait_valid(cyc);
    check("bp_latency", cyc, 10);
    for (int i = 0; i < 5; i++) begin
      in_valid   = i[0];
      input_data = xvec_t'($urandom);
      #1;
      check("bp_valid", out_valid_s[0], 1);
      check("bp_in_ready", in_ready_s[0], 0);
      check("bp_data", out_s[0], exp_y);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    h0        = hs_count;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("bp_one_hs", hs_count - h0, 1);
    check("bp_released", out_valid_s[0], 0);

    // Back-to-back: second vector captured on the first result's handshake edge.
    x  = xvec_t'($urandom);
    x2 = ~x;
    send(x, 1'b1);
    input_data = x2;
    wait_valid(cyc);
    check("b2b_latency", cyc, 10);
    check("b2b_in_ready", in_ready_s[0], 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_drop", out_valid_s[0], 0);
    check("b2b_busy", busy_s[0], 1);
    cyc = 1;
    while (!out_valid_s[0] && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("b2b_gap", cyc, 11);
    @(posedge clk);
    #1;

    // Reset in the middle of COMPUTE discards the run.
    send(xvec_t'($urandom), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_valid", out_valid_s[0], 0);
    check("abort_in_ready", in_ready_s[0], 1);
    check("abort_busy", busy_s[0], 0);
    for (int d = 0; d < 3; d++)
      check("abort_data", out_s[d], 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      seen |= out_valid_s[0];
    end
    check("abort_no_pulse", seen, 0);
    x = xvec_t'($urandom);
    send(x, 1'b0);
    wait_valid(cyc);
    check("post_abort_latency", cyc, 10);
    check("post_abort_data", out_s[0], model(W_A, B_A, 1'b1, x));
    @(posedge clk);
    #1;

    // Random traffic with random backpressure and idle gaps.
    h0 = hs_count;
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      begin
        bit captured;
        captured   = 1'b0;
        in_valid   = 1'b1;
        input_data = xvec_t'($urandom);
        for (int c = 0; c < 200 && !captured; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          #1;
          captured = in_ready_s[0];
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
        check("rand_capture", captured, 1);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && xq.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("rand_drain", xq.size(), 0);
    check("rand_hs", hs_count - h0, 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
